// File: rtl/uart_pkg.sv
// uart_pkg: shared types and parameter helpers for the UART blocks.
//   tx_state_t      - transmitter FSM states (PARITY is only reachable when
//                     UART_TX_PARITY_EN is defined).
//   baud_div()      - clock cycles per bit, integer divide.
//   *_ok()          - parameter-legality predicates, evaluated at elaboration.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return (baud > 0) ? clk_freq / baud : 0;
  endfunction

  function automatic bit frame_params_ok(input int clk_freq, input int baud,
                                         input int data_bits, input int stop_bits);
    return (baud_div(clk_freq, baud) >= 4) &&
           (data_bits >= 5) && (data_bits <= 8) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

  function automatic bit parity_sel_ok(input int parity_odd);
    return (parity_odd == 0) || (parity_odd == 1);
  endfunction

  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with a separate occupancy counter.
//   clk, rst_n   - clock, asynchronous active-low reset (control state only)
//   push, wdata  - write request / data; ignored while full
//   pop, rdata   - read request / head entry (combinational read of the head)
//   full         - registered, taken from next-state occupancy
//   empty, level - occupancy flags, level is 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count, count_next;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally at DEPTH (power of two); full/empty come from count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by an internal TX FIFO.
//   clk, rst_n  - clock, asynchronous active-low reset
//   tx_data     - byte to queue; bits above DATA_BITS-1 are ignored
//   tx_valid    - write request, accepted when tx_valid && tx_ready
//   tx_ready    - FIFO not full (registered)
//   txd         - serial line, LSB first, idles high
//   tx_busy     - FSM not idle or FIFO non-empty
//   fifo_level  - FIFO occupancy 0..FIFO_DEPTH
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int UART_BAUD  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, UART_BAUD);
  localparam int BW       = $clog2(BAUD_DIV);

  if (!frame_params_ok(CLK_FREQ, UART_BAUD, DATA_BITS, STOP_BITS) ||
      !parity_sel_ok(PARITY_ODD) || !fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter set");
  end

  tx_state_t     state, state_d;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic [7:0]    shift;
  logic          avail;
  logic          tick, pop, txd_d;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  logic par_bit;
`endif

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state != IDLE) || !fifo_empty;
  assign tick     = (baud_cnt == BW'(BAUD_DIV - 1));

  // IDLE looks at a registered copy of "FIFO non-empty", so a write into an
  // empty FIFO starts the frame two edges after it is accepted. STOP looks at
  // the live flag so back-to-back frames follow with no gap.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    txd_d   = txd;
    case (state)
      IDLE: begin
        if (avail) begin
          pop     = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          txd_d   = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_bit;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            // shift moves right on this same edge, so the next bit is shift[1]
            txd_d = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick && (stop_cnt == 1'(STOP_BITS - 1))) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      avail    <= 1'b0;
    end else begin
      state <= state_d;
      txd   <= txd_d;
      avail <= !fifo_empty;
      if ((state == IDLE) || tick) baud_cnt <= '0;
      else                         baud_cnt <= baud_cnt + 1'b1;
      if (pop)                          bit_cnt <= '0;
      else if ((state == DATA) && tick) bit_cnt <= bit_cnt + 1'b1;
      if (state != STOP) stop_cnt <= 1'b0;
      else if (tick)     stop_cnt <= stop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                          shift <= fifo_rdata;
    else if ((state == DATA) && tick) shift <= shift >> 1;
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (pop) par_bit <= (^(fifo_rdata & DATA_MASK)) ^ 1'(PARITY_ODD);
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int UART_BAUD = 100_000;
  localparam int BD        = CLK_FREQ / UART_BAUD;
  localparam int DEPTH     = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB0 = 11;
  localparam string E0 = "01010010101";
  localparam string E1 = "01000001011";
  localparam string E2 = "01000001111";
`else
  localparam int NB0 = 10;
  localparam string E0 = "0101001011";
  localparam string E1 = "0100000111";
  localparam string E2 = "0100000111";
`endif
  localparam int FLEN0 = NB0 * BD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       r0, r1, r2, txd0, txd1, txd2, b0, b1, b2;
  logic [4:0] l0, l1, l2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .UART_BAUD(UART_BAUD), .DATA_BITS(8),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
    .txd(txd0), .tx_busy(b0), .fifo_level(l0));

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .UART_BAUD(UART_BAUD), .DATA_BITS(7),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
    .txd(txd1), .tx_busy(b1), .fifo_level(l1));

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .UART_BAUD(UART_BAUD), .DATA_BITS(7),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r2),
    .txd(txd2), .tx_busy(b2), .fifo_level(l2));

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---- reference model of dut0 (8 data bits, 1 stop bit, even parity) ----
  logic [7:0] mq[$];
  int         mq_t[$];
  int         edge_n = 0;
  int         last_acc = 0;
  bit         f_act = 1'b0;
  int         f_start = 0;
  bit [15:0]  f_bits = '1;
  bit         m_ready = 1'b1;

  function automatic bit [15:0] frame_of(input logic [7:0] b);
    bit [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mq_t.delete();
      f_act   = 1'b0;
      m_ready = 1'b1;
    end else begin
      bit ending, start;
      edge_n++;
      ending = f_act && (edge_n == f_start + FLEN0);
      if (ending) f_act = 1'b0;
      start = 1'b0;
      if (!f_act && (mq.size() != 0)) begin
        if (ending)                      start = 1'b1;
        else if (mq_t[0] + 2 <= edge_n)  start = 1'b1;
      end
      if (start) begin
        f_bits  = frame_of(mq[0]);
        f_start = edge_n;
        f_act   = 1'b1;
        void'(mq.pop_front());
        void'(mq_t.pop_front());
      end
      if (v0 && m_ready) begin
        mq.push_back(d0);
        mq_t.push_back(edge_n);
        last_acc = edge_n;
      end
      m_ready = (mq.size() < DEPTH);
    end
  end

  function automatic logic exp_line();
    return f_act ? f_bits[(edge_n - f_start) / BD] : 1'b1;
  endfunction

  always @(negedge clk) begin
    if (go) begin
      chk("model_txd",   txd0, exp_line());
      chk("model_ready", r0,   m_ready);
      chk("model_busy",  b0,   (f_act || (mq.size() != 0)));
      chk("model_level", l0,   mq.size());
    end
  end

  // ---- helpers ----
  task automatic write0(input logic [7:0] b, input int budget);
    bit ok;
    int n;
    n  = 0;
    ok = 1'b0;
    v0 = 1'b1;
    d0 = b;
    while (!ok && (n < budget)) begin
      ok = m_ready;
      @(posedge clk);
      #1;
      n++;
    end
    v0 = 1'b0;
    d0 = 8'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: write of %0h not accepted within %0d cycles", b, budget);
    end
  endtask

  function automatic logic line_of(input int which);
    return (which == 0) ? txd0 : ((which == 1) ? txd1 : txd2);
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? b0 : ((which == 1) ? b1 : b2);
  endfunction

  // Called #1 after the edge that accepted the byte into an empty, idle DUT.
  task automatic check_frame(input string name, input int which, input string bits);
    wait_edges(1);
    chk({name, "_lat1"}, line_of(which), 1'b1);
    wait_edges(1);
    chk({name, "_fall"}, line_of(which), 1'b0);
    wait_edges(BD / 2);
    for (int k = 0; k < bits.len(); k++) begin
      if (k != 0) wait_edges(BD);
      chk($sformatf("%s_bit%0d", name, k), line_of(which), (bits[k] == "1"));
    end
    wait_edges(BD / 2 - 1);
    chk({name, "_busy_last"}, busy_of(which), 1'b1);
    wait_edges(1);
    chk({name, "_busy_end"}, busy_of(which), 1'b0);
    chk({name, "_line_end"}, line_of(which), 1'b1);
  endtask

  task automatic chk_idle_all(input string name);
    chk({name, "_txd0"}, txd0, 1'b1); chk({name, "_rdy0"}, r0, 1'b1);
    chk({name, "_bsy0"}, b0, 1'b0);   chk({name, "_lvl0"}, l0, 5'd0);
    chk({name, "_txd1"}, txd1, 1'b1); chk({name, "_rdy1"}, r1, 1'b1);
    chk({name, "_bsy1"}, b1, 1'b0);   chk({name, "_lvl1"}, l1, 5'd0);
    chk({name, "_txd2"}, txd2, 1'b1); chk({name, "_bsy2"}, b2, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n;
    #2 rst_n = 1'b0;
    wait_edges(3);
    chk_idle_all("t1_in_reset");
    rst_n = 1'b1;
    go    = 1'b1;
    wait_edges(100);
    chk_idle_all("t1_idle100");

    // single byte 0xA5 on the 8-bit instance
    write0(8'hA5, 10);
    check_frame("t2", 0, E0);
    wait_edges(20);

    // 7 data bits, 2 stop bits, 0x41 on both parity flavours
    chk("t4_ready1", r1, 1'b1);
    v1 = 1'b1;
    d1 = 8'h41;
    wait_edges(1);
    v1 = 1'b0;
    d1 = 8'hFF;
    fork
      check_frame("t4", 1, E1);
      check_frame("t5", 2, E2);
    join
    wait_edges(20);

    // burst of 17 while a frame is in flight: 17th stalls until the first pop
    write0(8'h3C, 10);
    a0 = last_acc;
    for (int j = 0; j < 16; j++) write0(8'($urandom), 5);
    chk("t3_level_full", l0, 5'd16);
    chk("t3_ready_low", r0, 1'b0);
    write0(8'hC3, 2 * FLEN0);
    chk("t3_stall_edge", last_acc - a0, FLEN0 + 3);
    n = 0;
    while (b0 && (n < 20 * FLEN0)) begin
      wait_edges(1);
      n++;
    end
    chk("t3_drain_len", edge_n - (a0 + 2), 18 * FLEN0);
    wait_edges(20);

    // reset in the middle of a frame with bytes still queued
    write0(8'h00, 10);
    write0(8'h11, 10);
    write0(8'h22, 10);
    wait_edges(35);
    chk("t6_pre_line", txd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_txd",   txd0, 1'b1);
    chk("t6_level", l0,   5'd0);
    chk("t6_ready", r0,   1'b1);
    chk("t6_busy",  b0,   1'b0);
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(300);
    chk_idle_all("t6_after");

    // randomized traffic against the model
    for (int i = 0; i < 70; i++) begin
      if ($urandom_range(0, 3) == 0) wait_edges($urandom_range(1, 2 * FLEN0));
      else                           write0(8'($urandom), 4 * FLEN0);
    end
    n = 0;
    while (b0 && (n < 20 * FLEN0)) begin
      wait_edges(1);
      n++;
    end
    chk("rand_drained", b0, 1'b0);
    chk("rand_line", txd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
